// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex decoder/driver for an N-digit common-anode 7-segment display.
// Latency: an/a2g/dp are registered and lag the scan counters by one cycle; data/digit_en/dp_in sampled live.
// Backpressure: none, free-running scan. Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero glyphs.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              a2g,
    output logic                    dp
);

    localparam int TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
        end
        if (BLANK_CYCLES < 0 || DIGIT_CYCLES <= BLANK_CYCLES) begin : g_bad_cycles
            $error("seg7_scan_driver: need 0 <= BLANK_CYCLES < DIGIT_CYCLES");
        end
    endgenerate

    logic [TW-1:0]         tick_cnt;
    logic [IW-1:0]         idx;
    logic                  tick_wrap;
    logic                  in_blank;
    logic [3:0]            nibble;
    logic                  suppress;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'b0000001;
            4'h1:    hex_glyph = 7'b1001111;
            4'h2:    hex_glyph = 7'b0010010;
            4'h3:    hex_glyph = 7'b0000110;
            4'h4:    hex_glyph = 7'b1001100;
            4'h5:    hex_glyph = 7'b0100100;
            4'h6:    hex_glyph = 7'b0100000;
            4'h7:    hex_glyph = 7'b0001111;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0000100;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b1100000;
            4'hC:    hex_glyph = 7'b0110001;
            4'hD:    hex_glyph = 7'b1000010;
            4'hE:    hex_glyph = 7'b0110000;
            default: hex_glyph = 7'b0111000;
        endcase
    endfunction

    assign tick_wrap = (tick_cnt == TW'(DIGIT_CYCLES - 1));
    assign nibble    = data[4*int'(idx) +: 4];

    // A zero-length gap must never blank, so skip the compare entirely.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (tick_cnt < TW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero;

    // upper_zero[i]: nibble i and every more-significant nibble are zero.
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = ((data >> (4*i)) == '0);
        end
    end

    // Digit 0 always shows its glyph so a zero value still reads "0".
    assign suppress = (idx != '0) && upper_zero[idx];
`else
    assign suppress = 1'b0;
`endif

    // Scan counters: tick within the slot, then advance to the next digit on slot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            idx      <= '0;
        end else if (tick_wrap) begin
            tick_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Decode the current slot; a disabled digit looks exactly like the blank gap.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        if (!in_blank && digit_en[idx]) begin
            an_nxt  = ~(NUM_DIGITS'(1) << idx);
            seg_nxt = suppress ? 7'b1111111 : hex_glyph(nibble);
            dp_nxt  = ~dp_in[idx];
        end
    end

    // Register the pin drive so the display sees glitch-free outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= '1;
            a2g <= 7'b1111111;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            a2g <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule
